pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on pwm_in; legal range 2..4.
REQ-002 Parameter TIMEOUT, default 2000000: cycles without a completing edge before the measurement is abandoned; legal range 2..2^32-1.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pwm_in  input  1  asynchronous PWM waveform to measure, e.g. a servo pulse train.
REQ-007 period_out  output  32  cycles between the last two synchronized rising edges.
REQ-008 on_time_out  output  32  high-time cycles of the last complete period.
REQ-009 meas_valid  output  1  one-cycle strobe marking an update of period_out and on_time_out.
REQ-010 timeout  output  1  level; set when TIMEOUT is reached, cleared by the next meas_valid.

Function
REQ-011 pwm_in SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized signal s against its one-cycle-delayed copy; rise = s & ~s_d, fall = ~s & s_d.
REQ-012 FSM states: IDLE (no reference edge), HIGH (s high after a rise), LOW (s low after a fall).
REQ-013 IDLE: a rise causes transition to HIGH, loads cnt_p<=1 and cnt_h<=1, and does not assert meas_valid.
REQ-014 HIGH: cnt_p and cnt_h increment each cycle; a fall causes hold_h<=cnt_h and transition to LOW.
REQ-015 LOW: cnt_p increments each cycle; a rise causes period_out<=cnt_p, on_time_out<=hold_h, meas_valid<=1, timeout<=0, cnt_p<=1, cnt_h<=1, and transition to HIGH.
REQ-016 Counting: a pulse high for H cycles in a period of P cycles (as seen on s) SHALL report on_time_out=H and period_out=P exactly.
REQ-017 Latency: outputs and meas_valid update on the clock edge ending the cycle in which rise is detected; meas_valid is high for exactly one cycle.
REQ-018 period_out and on_time_out SHALL hold their values between strobes.
REQ-019 Timeout: in HIGH or LOW, if cnt_p==TIMEOUT and no rise occurs in that cycle, the block goes to IDLE and sets timeout=1; period_out and on_time_out are held, and meas_valid is not asserted.
REQ-020 Simultaneous rise and cnt_p==TIMEOUT: the rise wins, REQ-015 applies, and timeout is not set.
REQ-021 Because cnt_p never exceeds TIMEOUT, counters SHALL never wrap; no saturation logic is needed.
REQ-022 pwm_in stuck high or stuck low SHALL end in a timeout; the first rise after a timeout resynchronizes per REQ-013.
REQ-023 A rise in HIGH or a fall in LOW is impossible by construction and SHALL need no handling.

Reset
REQ-024 rst asserted SHALL force state=IDLE, all synchronizer flops and s_d to 0, cnt_p=cnt_h=hold_h=0, period_out=0, on_time_out=0, meas_valid=0, timeout=0.
REQ-025 Reset mid-measurement SHALL discard the partial measurement; the first full period after deassertion is the first reported.
REQ-026 Deassertion with pwm_in already high SHALL produce a rise once synchronized, and IDLE SHALL treat it as the reference edge.

Structure
REQ-027 Package pwm_pkg SHALL hold CNT_W=32 and the capture state enum (IDLE, HIGH, LOW).
REQ-028 Sub-module pwm_sync SHALL implement the SYNC_STAGES synchronizer and rise/fall detection, with outputs s, rise, and fall.
REQ-029 FSM, counters, and output registers SHALL reside in pwm_capture; all outputs are registered.

Verification
REQ-030 Drive pwm_in with 1500 cycles high and 18500 cycles low, repeated 3 times -> exactly 2 meas_valid strobes, each with period_out=20000 and on_time_out=1500.
REQ-031 After one steady period, change the on-time to 1000 -> the next strobe reports on_time_out=1000 and period_out=20000.
REQ-032 With TIMEOUT=100, hold pwm_in high for 200 cycles -> timeout=1 exactly 100 cycles after the rise is detected, no strobe, outputs hold 0; then drive two periods of 20/50 -> one strobe with 20/50 and timeout=0.
REQ-033 With TIMEOUT=50, place the second rise so that cnt_p==50 in the detect cycle -> strobe with period_out=50 and timeout stays 0.
REQ-034 Assert rst mid-HIGH, then release -> all outputs 0, no strobe for the partial period, and the first strobe comes after two subsequent rises.
REQ-035 Minimal waveform of 1 cycle high and 1 cycle low, repeated -> strobes every 2 cycles with period_out=2 and on_time_out=1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared counter width and capture-state encoding for the PWM capture block.
package pwm_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_sync.sv
// Multi-flop synchronizer for the asynchronous PWM input plus single-cycle
// rise/fall detection on the synchronized level.
module pwm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures rise-to-rise period and high time of pwm_in, with a
// watchdog that abandons a measurement when no edge completes it in time.
//
// state | meaning
// IDLE  | no reference rise yet (after reset or after a timeout)
// HIGH  | s high since the reference rise; counting period and high time
// LOW   | s low after the fall; counting the rest of the period
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] TIMEOUT     = 32'd2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] on_time_out,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cap_state_t       state;
  logic [CNT_W-1:0] cnt_p;
  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] hold_h;
  logic             rise;
  logic             fall;
  logic             s_unused;
  logic             at_limit;

  pwm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .s     (s_unused),
    .rise  (rise),
    .fall  (fall)
  );

  // cnt_p stops at TIMEOUT, so the counters can never wrap.
  assign at_limit = (cnt_p == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_p       <= '0;
      cnt_h       <= '0;
      hold_h      <= '0;
      period_out  <= '0;
      on_time_out <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            cnt_p <= ONE;
            cnt_h <= ONE;
          end
        end
        HIGH: begin
          if (at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            cnt_p <= cnt_p + ONE;
            cnt_h <= cnt_h + ONE;
            if (fall) begin
              hold_h <= cnt_h;
              state  <= LOW;
            end
          end
        end
        LOW: begin
          // A rise in the limit cycle still completes the period.
          if (rise) begin
            period_out  <= cnt_p;
            on_time_out <= hold_h;
            meas_valid  <= 1'b1;
            timeout     <= 1'b0;
            cnt_p       <= ONE;
            cnt_h       <= ONE;
            state       <= HIGH;
          end else if (at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else begin
            cnt_p <= cnt_p + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table vectors, corner sequences and random waveforms,
// all compared every cycle against an edge-timeline reference model.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int N = 4;
  localparam int TMO [N] = '{2000000, 100, 50, 2000000};
  localparam int SYN [N] = '{2, 2, 3, 4};

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       pwm;
  logic [N-1:0][31:0] per;
  logic [N-1:0][31:0] ont;
  logic [N-1:0]       mv;
  logic [N-1:0]       to;

  always #5 clk = ~clk;

  pwm_capture #(.SYNC_STAGES(2), .TIMEOUT(32'd2000000)) dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm[0]), .period_out(per[0]),
    .on_time_out(ont[0]), .meas_valid(mv[0]), .timeout(to[0]));
  pwm_capture #(.SYNC_STAGES(2), .TIMEOUT(32'd100)) dut1 (
    .clk(clk), .rst(rst), .pwm_in(pwm[1]), .period_out(per[1]),
    .on_time_out(ont[1]), .meas_valid(mv[1]), .timeout(to[1]));
  pwm_capture #(.SYNC_STAGES(3), .TIMEOUT(32'd50)) dut2 (
    .clk(clk), .rst(rst), .pwm_in(pwm[2]), .period_out(per[2]),
    .on_time_out(ont[2]), .meas_valid(mv[2]), .timeout(to[2]));
  pwm_capture #(.SYNC_STAGES(4), .TIMEOUT(32'd2000000)) dut3 (
    .clk(clk), .rst(rst), .pwm_in(pwm[3]), .period_out(per[3]),
    .on_time_out(ont[3]), .meas_valid(mv[3]), .timeout(to[3]));

  // Reference model: works on the cycle numbers at which the bench changes
  // pwm_in; results appear SYNC_STAGES+1 edges later.
  typedef struct {
    int t;
    int idx;
    bit strobe;
    int per;
    int on;
  } ev_t;

  typedef struct {
    int idx;
    int hi;
    int lo;
    int reps;
    int n_strobe;
    int per;
    int on;
    bit to;
  } vec_t;

  ev_t         evq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          nxt_rst = 1'b1;
  bit [N-1:0]  nxt_pwm = '0;
  bit          prev [N];
  bit          ref_ok [N];
  int          last_rise [N];
  int          last_fall [N];
  int unsigned exp_per [N];
  int unsigned exp_on [N];
  bit          exp_mv [N];
  bit          exp_to [N];
  int          strobes [N];
  vec_t        vecs [7];

  task automatic model_reset();
    evq.delete();
    for (int i = 0; i < N; i++) begin
      prev[i] = 1'b0;  ref_ok[i] = 1'b0;
      last_rise[i] = 0; last_fall[i] = 0;
      exp_per[i] = 0;  exp_on[i] = 0;
      exp_mv[i] = 1'b0; exp_to[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i, bit lvl);
    int k = cyc;
    if (ref_ok[i] && (k - last_rise[i]) == TMO[i] + 1) begin
      evq.push_back('{last_rise[i] + SYN[i] + 1 + TMO[i], i, 1'b0, 0, 0});
      ref_ok[i] = 1'b0;
    end
    if (lvl && !prev[i]) begin
      if (ref_ok[i])
        evq.push_back('{k + SYN[i] + 1, i, 1'b1, k - last_rise[i], last_fall[i] - last_rise[i]});
      ref_ok[i] = 1'b1;
      last_rise[i] = k;
    end
    if (!lvl && prev[i]) last_fall[i] = k;
    prev[i] = lvl;
  endtask

  task automatic check_cycle();
    for (int i = 0; i < N; i++) begin
      checks++;
      strobes[i] += int'(mv[i]);
      if (mv[i] !== exp_mv[i] || to[i] !== exp_to[i] ||
          per[i] !== exp_per[i] || ont[i] !== exp_on[i]) begin
        errors++;
        $display("FAIL model inst%0d cyc %0d: got mv=%0b to=%0b per=%0d on=%0d, want mv=%0b to=%0b per=%0d on=%0d",
                 i, cyc, mv[i], to[i], per[i], ont[i], exp_mv[i], exp_to[i], exp_per[i], exp_on[i]);
      end
    end
  endtask

  task automatic tick();
    ev_t e;
    int  j;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) exp_mv[i] = 1'b0;
    j = 0;
    while (j < evq.size()) begin
      if (evq[j].t == cyc) begin
        e = evq[j];
        if (e.strobe) begin
          exp_mv[e.idx] = 1'b1;  exp_to[e.idx] = 1'b0;
          exp_per[e.idx] = e.per; exp_on[e.idx] = e.on;
        end else begin
          exp_to[e.idx] = 1'b1;
        end
        evq.delete(j);
      end else begin
        j++;
      end
    end
    #1;
    check_cycle();
    if (nxt_rst && !rst) model_reset();
    rst = nxt_rst;
    pwm = nxt_pwm;
    if (!rst)
      for (int i = 0; i < N; i++) model_step(i, nxt_pwm[i]);
  endtask

  task automatic run(int i, bit lvl, int n);
    nxt_pwm[i] = lvl;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    nxt_pwm = '0;
    nxt_rst = 1'b1;
    repeat (3) tick();
    nxt_rst = 1'b0;
    tick();
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int base;
    int b3;
    int k0;
    int idx;
    int rem [N];

    //          idx  hi  lo reps strobes per  on  to
    vecs[0] = '{0,   1,  1, 20,  19,      2,  1, 1'b0};
    vecs[1] = '{1,  20, 30,  4,   3,     50, 20, 1'b0};
    vecs[2] = '{2,  25, 25,  3,   2,     50, 25, 1'b0};
    vecs[3] = '{2,  10, 45,  3,   0,      0,  0, 1'b1};
    vecs[4] = '{3,   7,  5,  5,   4,     12,  7, 1'b0};
    vecs[5] = '{1,  60, 41,  2,   0,      0,  0, 1'b1};
    vecs[6] = '{1,  60, 40,  3,   2,    100, 60, 1'b0};

    rst = 1'b1;
    pwm = '0;
    model_reset();
    for (int i = 0; i < N; i++) strobes[i] = 0;
    do_reset();
    chk("reset_per", per[0], 0);
    chk("reset_to", to[0], 0);

    foreach (vecs[v]) begin
      do_reset();
      idx  = vecs[v].idx;
      base = strobes[idx];
      for (int r = 0; r < vecs[v].reps; r++) begin
        run(idx, 1'b1, vecs[v].hi);
        run(idx, 1'b0, vecs[v].lo);
      end
      run(idx, 1'b0, 2);
      chk($sformatf("vec%0d_strobes", v), strobes[idx] - base, vecs[v].n_strobe);
      chk($sformatf("vec%0d_period", v), per[idx], vecs[v].per);
      chk($sformatf("vec%0d_on_time", v), ont[idx], vecs[v].on);
      chk($sformatf("vec%0d_timeout", v), to[idx], vecs[v].to);
    end

    // Stuck high with TIMEOUT=100, then two 20/50 periods.
    do_reset();
    base = strobes[1];
    nxt_pwm[1] = 1'b1;
    tick();
    k0 = cyc;
    for (int c = 1; c < 200; c++) begin
      tick();
      if (cyc == k0 + SYN[1] + TMO[1]) chk("to_before_limit", to[1], 0);
      if (cyc == k0 + SYN[1] + 1 + TMO[1]) chk("to_at_limit", to[1], 1);
    end
    chk("stuck_strobes", strobes[1] - base, 0);
    chk("stuck_period", per[1], 0);
    chk("stuck_on_time", ont[1], 0);
    run(1, 1'b0, 10);
    run(1, 1'b1, 20); run(1, 1'b0, 30);
    run(1, 1'b1, 20); run(1, 1'b0, 32);
    chk("resync_strobes", strobes[1] - base, 1);
    chk("resync_period", per[1], 50);
    chk("resync_on_time", ont[1], 20);
    chk("resync_timeout", to[1], 0);

    // Reset in the middle of a high phase discards the partial period.
    do_reset();
    run(0, 1'b1, 10); run(0, 1'b0, 20);
    run(0, 1'b1, 10); run(0, 1'b0, 20);
    run(0, 1'b1, 4);
    chk("pre_rst_period", per[0], 30);
    nxt_rst = 1'b1;
    repeat (3) tick();
    chk("mid_rst_period", per[0], 0);
    chk("mid_rst_on_time", ont[0], 0);
    nxt_rst = 1'b0;
    nxt_pwm[0] = 1'b0;
    tick();
    base = strobes[0];
    run(0, 1'b0, 5); run(0, 1'b1, 10); run(0, 1'b0, 20);
    chk("post_rst_no_strobe", strobes[0] - base, 0);
    run(0, 1'b1, 5);
    chk("post_rst_strobes", strobes[0] - base, 1);
    chk("post_rst_period", per[0], 30);
    chk("post_rst_on_time", ont[0], 10);

    // Release reset with pwm_in already high: that rise is the reference.
    nxt_pwm = '0;
    nxt_pwm[2] = 1'b1;
    nxt_rst = 1'b1;
    repeat (3) tick();
    nxt_rst = 1'b0;
    run(2, 1'b1, 6); run(2, 1'b0, 10); run(2, 1'b1, 5);
    chk("rel_high_period", per[2], 16);
    chk("rel_high_on_time", ont[2], 6);

    // Servo-like train on inst0; on-time change after one period on inst3.
    do_reset();
    base = strobes[0];
    b3   = strobes[3];
    for (int c = 0; c < 60002; c++) begin
      nxt_pwm[0] = (c < 60000) && ((c % 20000) < 1500);
      nxt_pwm[3] = (c < 20000) ? (c < 1500) : ((c < 41000) && ((c % 20000) < 1000));
      tick();
    end
    chk("servo_strobes", strobes[0] - base, 2);
    chk("servo_period", per[0], 20000);
    chk("servo_on_time", ont[0], 1500);
    chk("change_strobes", strobes[3] - b3, 2);
    chk("change_period", per[3], 20000);
    chk("change_on_time", ont[3], 1000);

    // Random segment lengths, occasionally long enough to time out.
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 1; i <= 2; i++) begin
        if (rem[i] == 0) begin
          nxt_pwm[i] = ~nxt_pwm[i];
          rem[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 130))
                                               : int'($urandom_range(1, 30));
        end else begin
          rem[i]--;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
